// File: rtl/core_lsu.sv
// Load/store unit: one core request at a time turned into a word-aligned bus access, load data extended for writeback.
// Optional misaligned-access trap enabled by defining CORE_LSU_MISALIGN_TRAP_EN.
module core_lsu (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        BUS_VALID,
  input  logic        BUS_READY,
  output logic        BUS_WE,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT_RD, S_RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        unsigned_q, unsigned_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  req_size;
  logic        trap;

  // Size 3 is folded into word once, so nothing downstream has to special-case it.
  assign req_size = (REQ_SIZE == 2'd3) ? SZ_WORD : REQ_SIZE;

`ifdef CORE_LSU_MISALIGN_TRAP_EN
  logic rsp_err_q, rsp_err_d;
  assign trap = ((req_size == SZ_HALF) && REQ_ADDR[0]) ||
                ((req_size == SZ_WORD) && (REQ_ADDR[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] lo,
                                          input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_BYTE: extract = {{24{b[7] & ~uns}}, b};
      SZ_HALF: extract = {{16{h[15] & ~uns}}, h};
      default: extract = rd;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (REQ_VALID) state_d = trap ? S_RESP : S_BUS;
      S_BUS:     if (BUS_READY) state_d = bus_we_q ? S_RESP : S_WAIT_RD;
      S_WAIT_RD: if (BUS_RVALID) state_d = S_RESP;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = (state_q == S_IDLE) && !RST;
    BUS_VALID = (state_q == S_BUS);
    RSP_VALID = (state_q == S_RESP);
  end

  always_comb begin
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    unsigned_d  = unsigned_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    rsp_err_d   = rsp_err_q;
`endif
    if (state_q == S_IDLE && REQ_VALID) begin
      if (trap) begin
        rsp_rdata_d = 32'h0;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
        rsp_err_d   = 1'b1;
`endif
      end else begin
        size_d     = req_size;
        addr_lo_d  = REQ_ADDR[1:0];
        unsigned_d = REQ_UNSIGNED;
        bus_we_d   = REQ_WE;
        bus_addr_d = {REQ_ADDR[31:2], 2'b00};
        case (req_size)
          SZ_BYTE: begin
            bus_be_d    = 4'b0001 << REQ_ADDR[1:0];
            bus_wdata_d = {4{REQ_WDATA[7:0]}};
          end
          SZ_HALF: begin
            bus_be_d    = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
            bus_wdata_d = {2{REQ_WDATA[15:0]}};
          end
          default: begin
            bus_be_d    = 4'b1111;
            bus_wdata_d = REQ_WDATA;
          end
        endcase
      end
    end
    // Response registers change only on the way into RESP and hold until the next one.
    if (state_q == S_BUS && BUS_READY && bus_we_q) begin
      rsp_rdata_d = 32'h0;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      rsp_err_d   = 1'b0;
`endif
    end
    if (state_q == S_WAIT_RD && BUS_RVALID) begin
      rsp_rdata_d = extract(BUS_RDATA, addr_lo_q, size_q, unsigned_q);
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      rsp_err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      size_q      <= SZ_BYTE;
      addr_lo_q   <= 2'b00;
      unsigned_q  <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'b0000;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      rsp_rdata_q <= 32'h0;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      unsigned_q  <= unsigned_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign BUS_WE    = bus_we_q;
  assign BUS_BE    = bus_be_q;
  assign BUS_ADDR  = bus_addr_q;
  assign BUS_WDATA = bus_wdata_q;
  assign RSP_RDATA = rsp_rdata_q;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
  assign RSP_ERR   = rsp_err_q;
`else
  assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed load/store transactions, response contents scored from a queue.
module tb_core_lsu;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  core_lsu dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we), .REQ_SIZE(req_size),
    .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .BUS_VALID(bus_valid), .BUS_READY(bus_ready), .BUS_WE(bus_we), .BUS_BE(bus_be),
    .BUS_ADDR(bus_addr), .BUS_WDATA(bus_wdata), .BUS_RVALID(bus_rvalid), .BUS_RDATA(bus_rdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Drives cycle 0 of a request; returns at the start of cycle 1 with the request inputs scrambled.
  task automatic start_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wdata;
  endtask

  task automatic run_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    bus_ready = 1'b1;
    start_req(1'b1, size, 1'b0, addr, wdata);
    @(negedge clk);
    check("st_bus_valid", {31'b0, bus_valid}, 32'd1);
    check("st_bus_we", {31'b0, bus_we}, 32'd1);
    check("st_bus_addr", bus_addr, {addr[31:2], 2'b00});
    check("st_bus_be", {28'b0, bus_be}, {28'b0, exp_be});
    check("st_bus_wdata", bus_wdata, exp_wdata);
    check("st_req_ready_busy", {31'b0, req_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("st_rsp_valid_c2", {31'b0, rsp_valid}, 32'd1);
    tick();
    @(negedge clk);
    check("st_rsp_valid_c3", {31'b0, rsp_valid}, 32'd0);
    check("st_req_ready_c3", {31'b0, req_ready}, 32'd1);
    tick();
  endtask

  task automatic run_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [31:0] rdata, input int waits,
                          input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    sb.push_back('{rdata: exp_rdata, err: 1'b0});
    bus_ready = (waits == 0);
    start_req(1'b0, size, uns, addr, 32'h5A5A_5A5A);
    @(negedge clk);
    check("ld_bus_valid", {31'b0, bus_valid}, 32'd1);
    check("ld_bus_we", {31'b0, bus_we}, 32'd0);
    check("ld_bus_addr", bus_addr, {addr[31:2], 2'b00});
    check("ld_bus_be", {28'b0, bus_be}, {28'b0, exp_be});
    for (int i = 1; i <= waits; i++) begin
      tick();
      if (i == waits) bus_ready = 1'b1;
      @(negedge clk);
      check("ld_wait_bus_valid", {31'b0, bus_valid}, 32'd1);
      check("ld_wait_bus_addr", bus_addr, {addr[31:2], 2'b00});
      check("ld_wait_bus_be", {28'b0, bus_be}, {28'b0, exp_be});
      check("ld_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    check("ld_rd_bus_valid", {31'b0, bus_valid}, 32'd0);
    check("ld_rd_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    bus_rvalid = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    check("ld_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    check({phase, "_bus_valid"}, {31'b0, bus_valid}, 32'd0);
    check({phase, "_bus_we"}, {31'b0, bus_we}, 32'd0);
    check({phase, "_bus_be"}, {28'b0, bus_be}, 32'd0);
    check({phase, "_bus_addr"}, bus_addr, 32'd0);
    check({phase, "_bus_wdata"}, bus_wdata, 32'd0);
    check({phase, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({phase, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({phase, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", {31'b0, req_ready}, 32'd1);
    tick();

    run_store(2'd0, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    run_store(2'd1, 32'h0000_1002, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    run_store(2'd3, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    run_load(2'd1, 1'b0, 32'h0000_2002, 32'h8001_1234, 0, 4'b1100, 32'hFFFF_8001);
    run_load(2'd1, 1'b1, 32'h0000_2002, 32'h8001_1234, 0, 4'b1100, 32'h0000_8001);
    run_load(2'd1, 1'b0, 32'h0000_2000, 32'h8001_9234, 0, 4'b0011, 32'hFFFF_9234);
    run_load(2'd0, 1'b0, 32'h0000_3001, 32'h0000_7F00, 3, 4'b0010, 32'h0000_007F);
    run_load(2'd0, 1'b0, 32'h0000_3002, 32'h0080_0000, 0, 4'b0100, 32'hFFFF_FF80);
    run_load(2'd0, 1'b1, 32'h0000_3003, 32'hF100_0000, 1, 4'b1000, 32'h0000_00F1);
    run_load(2'd2, 1'b0, 32'h0000_5000, 32'h1357_9BDF, 0, 4'b1111, 32'h1357_9BDF);

`ifdef CORE_LSU_MISALIGN_TRAP_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    bus_ready = 1'b1;
    start_req(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0);
    @(negedge clk);
    check("mis_rsp_valid_c1", {31'b0, rsp_valid}, 32'd1);
    check("mis_bus_valid_c1", {31'b0, bus_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("mis_bus_valid_c2", {31'b0, bus_valid}, 32'd0);
    check("mis_req_ready_c2", {31'b0, req_ready}, 32'd1);
    tick();
`else
    run_load(2'd2, 1'b0, 32'h0000_4002, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
`endif

    // Reset while waiting for read data: the late read beat must be dropped.
    bus_ready = 1'b1;
    start_req(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0);
    tick();
    bus_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("post_rst_idle_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    run_store(2'd2, 32'h0000_7000, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
